// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: receiver FSM state encodings, transmitter modes and parity helper.
package uart_receiver_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_MODE_IDLE  = 2'd0,
        TX_MODE_START = 2'd1,
        TX_MODE_DATA  = 2'd2,
        TX_MODE_STOP  = 2'd3
    } tx_mode_e;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_rx_bitcnt.sv
// Bit-period timer for the UART receiver: free-running counter with clear,
// flagging the half-bit and full-bit points of each bit period.
module uart_rx_bitcnt #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic CLK,
    input  logic RESET,
    input  logic CLEAR,
    output logic HALF_TICK,
    output logic FULL_TICK
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RESET || CLEAR) begin
            cnt <= '0;
        end else if (FULL_TICK) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign HALF_TICK = (cnt == HALF_LAST);
    assign FULL_TICK = (cnt == FULL_LAST);

endmodule

// File: rtl/uart_receiver.sv
// UART receiver, 8 data bits LSB first, one stop bit. Defining UART_RX_PARITY_EN
// adds an even parity bit before the stop bit, the PARITY state and the PERR output.
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RXD,
    output logic [7:0] DATA,
    output logic       VALID,
    output logic       BUSY,
    output logic       FERR,
`ifdef UART_RX_PARITY_EN
    output logic       PERR,
`endif
    output logic [2:0] STATE
);

    // VALID is a one-cycle strobe with no back-pressure: DATA is updated on the
    // same edge VALID rises and holds until the next good frame or reset.

    rx_state_e state;
    rx_state_e state_next;

    logic       sync1;
    logic       rxs;
    logic [7:0] shift;
    logic [2:0] bit_idx;
    logic       clr_cnt;
    logic       half_tick;
    logic       full_tick;
    logic       shift_en;
    logic       stop_sample;
    logic       par_err;
    logic       valid_d;
    logic       ferr_d;
`ifdef UART_RX_PARITY_EN
    logic       par_sample;
    logic       perr_d;
`else
    assign par_err = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= RXD;
            rxs   <= sync1;
        end
    end

    uart_rx_bitcnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bitcnt (
        .CLK      (CLK),
        .RESET    (RESET),
        .CLEAR    (clr_cnt),
        .HALF_TICK(half_tick),
        .FULL_TICK(full_tick)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= RX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        clr_cnt     = 1'b0;
        shift_en    = 1'b0;
        stop_sample = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_sample  = 1'b0;
`endif
        case (state)
            RX_IDLE: begin
                clr_cnt = 1'b1;
                if (!rxs) begin
                    state_next = RX_START;
                end
            end
            RX_START: begin
                // Mid start bit: a line already back high was only a glitch.
                if (half_tick) begin
                    clr_cnt    = 1'b1;
                    state_next = rxs ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (full_tick) begin
                    clr_cnt  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_next = RX_PARITY;
`else
                        state_next = RX_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (full_tick) begin
                    clr_cnt    = 1'b1;
                    par_sample = 1'b1;
                    state_next = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (full_tick) begin
                    clr_cnt     = 1'b1;
                    stop_sample = 1'b1;
                    state_next  = RX_IDLE;
                end
            end
            default: begin
                clr_cnt    = 1'b1;
                state_next = RX_IDLE;
            end
        endcase
    end

    always_comb begin
        valid_d = stop_sample & rxs & ~par_err;
        ferr_d  = stop_sample & ~rxs;
`ifdef UART_RX_PARITY_EN
        perr_d  = stop_sample & par_err;
`endif
    end

    assign BUSY  = (state != RX_IDLE);
    assign STATE = state;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            shift   <= 8'h00;
            bit_idx <= 3'd0;
            DATA    <= 8'h00;
            VALID   <= 1'b0;
            FERR    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err <= 1'b0;
            PERR    <= 1'b0;
`endif
        end else begin
            VALID <= valid_d;
            FERR  <= ferr_d;
            if (valid_d) begin
                DATA <= shift;
            end
            if (state == RX_IDLE) begin
                bit_idx <= 3'd0;
            end
            if (shift_en) begin
                shift   <= {rxs, shift[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
`ifdef UART_RX_PARITY_EN
            PERR <= perr_d;
            if (state == RX_IDLE) begin
                par_err <= 1'b0;
            end
            if (par_sample) begin
                par_err <= (rxs != even_parity(shift));
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver at CLKS_PER_BIT=8; build with
// UART_RX_PARITY_EN defined to also exercise the parity path.
module tb_uart_receiver;

    localparam int C = 8;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif
    // Start-bit negedge to VALID-visible negedge: 3 sync/detect cycles, half bit, rest of frame.
    localparam int LAT = 3 + C / 2 + NB * C;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       RXD;
    logic [7:0] DATA;
    logic       VALID;
    logic       BUSY;
    logic       FERR;
    logic       PERR;
    logic [2:0] STATE;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [10:0] exp_q[$];
    int          exp_t_q[$];
    logic [7:0]  last_data = 8'h00;
    logic [10:0] mon_e;
    int          mon_t;

    uart_receiver #(
        .CLKS_PER_BIT(C)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .RXD  (RXD),
        .DATA (DATA),
        .VALID(VALID),
        .BUSY (BUSY),
        .FERR (FERR),
`ifdef UART_RX_PARITY_EN
        .PERR (PERR),
`endif
        .STATE(STATE)
    );

`ifndef UART_RX_PARITY_EN
    assign PERR = 1'b0;
`endif

    // Clock and cycle count
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: each output event is {VALID, PERR, FERR, DATA}
    always @(negedge CLK) begin
        if (VALID || FERR || PERR) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: got v=%b p=%b f=%b data=0x%0h expected no event (cycle %0d)",
                         VALID, PERR, FERR, DATA, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                mon_t = exp_t_q.pop_front();
                check("rx_event", 32'({VALID, PERR, FERR, DATA}), 32'(mon_e));
                check("rx_latency", cyc, mon_t);
            end
        end
    end

    // Driver: called on a negedge, returns on the negedge ending the stop bit
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bad);
        logic v;
        logic fe;
        logic pe;
        v  = stop_bit && !par_bad;
        fe = !stop_bit;
`ifdef UART_RX_PARITY_EN
        pe = par_bad;
`else
        pe = 1'b0;
`endif
        if (v) last_data = b;
        exp_q.push_back({v, pe, fe, last_data});
        exp_t_q.push_back(cyc + LAT);
        RXD = 1'b0;
        repeat (C) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            repeat (C) @(negedge CLK);
        end
`ifdef UART_RX_PARITY_EN
        RXD = (^b) ^ par_bad;
        repeat (C) @(negedge CLK);
`endif
        RXD = stop_bit;
        repeat (C) @(negedge CLK);
        RXD = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, 32'(DATA), 32'h00);
        check({tag, "_valid"}, 32'(VALID), 32'h0);
        check({tag, "_ferr"}, 32'(FERR), 32'h0);
        check({tag, "_perr"}, 32'(PERR), 32'h0);
        check({tag, "_busy"}, 32'(BUSY), 32'h0);
        check({tag, "_state"}, 32'(STATE), 32'h0);
    endtask

    initial begin
        logic [7:0] partial;
        RESET = 1'b1;
        RXD   = 1'b1;
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        RESET = 1'b0;
        repeat (5) @(negedge CLK);
        check("idle_busy", 32'(BUSY), 32'h0);

        send_frame(8'hA5, 1'b1, 1'b0);
        check("busy_after_a5", 32'(BUSY), 32'h0);
        repeat (10) @(negedge CLK);

        // Two-cycle low glitch must be rejected at the half-bit check
        RXD = 1'b0;
        repeat (2) @(negedge CLK);
        RXD = 1'b1;
        repeat (2) @(negedge CLK);
        check("glitch_busy_start", 32'(BUSY), 32'h1);
        repeat (4) @(negedge CLK);
        check("glitch_busy_end", 32'(BUSY), 32'h0);
        repeat (10) @(negedge CLK);

        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (20) @(negedge CLK);

        send_frame(8'h01, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h80, 1'b1, 1'b0);
        repeat (10) @(negedge CLK);

        // Abort a frame after four data bits with reset
        partial = 8'h33;
        RXD = 1'b0;
        repeat (C) @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            RXD = partial[i];
            repeat (C) @(negedge CLK);
        end
        RESET = 1'b1;
        RXD   = 1'b1;
        @(negedge CLK);
        check_reset_outputs("midreset");
        @(negedge CLK);
        RESET = 1'b0;
        last_data = 8'h00;
        repeat (10) @(negedge CLK);
        send_frame(8'h5A, 1'b1, 1'b0);
        repeat (10) @(negedge CLK);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (10) @(negedge CLK);
        send_frame(8'h07, 1'b1, 1'b0);
        repeat (10) @(negedge CLK);
`endif

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge CLK);
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
